shift_barrelpipe: RTL and testbench

SHIFT_BARRELPIPE -- requirements
Module: shift_barrelpipe

---
 rtl/shift_pkg.sv | 23 ++
 rtl/shift_barrelpipe_stage.sv | 108 ++++++++++
 rtl/shift_barrelpipe.sv | 88 ++++++++
 tb/tb_shift_barrelpipe.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared definitions for the pipelined barrel shifter: mode encoding and a
// width helper used to size the shift-amount field.
package shift_pkg;

  // Shift/rotate operation selected per request
  typedef enum logic [1:0] {
    SH_ROR = 2'b00,
    SH_ROL = 2'b01,
    SH_LSR = 2'b10,
    SH_ASR = 2'b11
  } shift_mode_e;

  // Smallest r with 2**r >= n (n is a power of two, so this is log2(n))
  function automatic int unsigned log2w(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/shift_barrelpipe_stage.sv
// One pipeline stage of the barrel shifter: applies mux levels Lo..Lo+Num-1
// to the incoming operand, then registers data, amount, mode and valid.
// SHIFT_BARRELPIPE_STICKY_EN adds a sticky bit that ORs shifted-out bits.
module shift_barrelpipe_stage
  import shift_pkg::*;
#(
  parameter int unsigned Bits = 64,
  parameter int unsigned ShW  = 6,
  parameter int unsigned Lo   = 0,
  parameter int unsigned Num  = 1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            i_valid,
  output logic            o_retry,
  input  logic [Bits-1:0] i_data,
  input  logic [ShW-1:0]  i_sh,
  input  logic [1:0]      i_mode,
`ifdef SHIFT_BARRELPIPE_STICKY_EN
  input  logic            i_sticky,
  output logic            o_sticky,
`endif
  output logic            o_valid,
  input  logic            i_retry,
  output logic [Bits-1:0] o_data,
  output logic [ShW-1:0]  o_sh,
  output logic [1:0]      o_mode
);

  logic            r_valid;
  logic [Bits-1:0] r_data;
  logic [ShW-1:0]  r_sh;
  logic [1:0]      r_mode;
  logic            w_ready;
  logic [Bits-1:0] w_lvl_d [Num+1];
`ifdef SHIFT_BARRELPIPE_STICKY_EN
  logic            r_sticky;
  logic            w_lvl_st [Num+1];
`endif

  // Single mux level: move the operand by a fixed power-of-two distance
  function automatic logic [Bits-1:0] lvl_shift(input logic [Bits-1:0] d,
                                                input logic [1:0] m,
                                                input int unsigned sa);
    logic [Bits-1:0] r;
    r = d;
    case (shift_mode_e'(m))
      SH_ROR:  r = (d >> sa) | (d << (Bits - sa));
      SH_ROL:  r = (d << sa) | (d >> (Bits - sa));
      SH_LSR:  r = d >> sa;
      SH_ASR:  r = Bits'($signed(d) >>> sa);
      default: r = d;
    endcase
    return r;
  endfunction

  assign w_lvl_d[0] = i_data;
`ifdef SHIFT_BARRELPIPE_STICKY_EN
  assign w_lvl_st[0] = i_sticky;
`endif

  // Mux levels owned by this stage; level k moves by 2**k when i_sh[k] is set
  for (genvar g = 0; g < Num; g++) begin : g_lvl
    localparam int unsigned Sa = 32'd1 << (Lo + g);
    assign w_lvl_d[g+1] = i_sh[Lo+g] ? lvl_shift(w_lvl_d[g], i_mode, Sa) : w_lvl_d[g];
`ifdef SHIFT_BARRELPIPE_STICKY_EN
    // Bits dropped by a right shift are the low Sa bits; rotates drop nothing
    assign w_lvl_st[g+1] = w_lvl_st[g] |
                           (i_sh[Lo+g] & i_mode[1] & (|(w_lvl_d[g] << (Bits - Sa))));
`endif
  end

  // Load when empty or when the current contents leave this cycle
  assign w_ready = !r_valid || !i_retry;
  assign o_retry = !w_ready;

  // Stage register with bubble collapsing
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid  <= 1'b0;
      r_data   <= '0;
      r_sh     <= '0;
      r_mode   <= 2'b00;
`ifdef SHIFT_BARRELPIPE_STICKY_EN
      r_sticky <= 1'b0;
`endif
    end else if (w_ready) begin
      r_valid <= i_valid;
      if (i_valid) begin
        r_data   <= w_lvl_d[Num];
        r_sh     <= i_sh;
        r_mode   <= i_mode;
`ifdef SHIFT_BARRELPIPE_STICKY_EN
        r_sticky <= w_lvl_st[Num];
`endif
      end
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_sh    = r_sh;
  assign o_mode  = r_mode;
`ifdef SHIFT_BARRELPIPE_STICKY_EN
  assign o_sticky = r_sticky;
`endif

endmodule

// File: rtl/shift_barrelpipe.sv
// Pipelined barrel shifter/rotator with valid/retry handshakes on both sides.
// log2(Bits) mux levels are split across Stages registered stages.
// Optional feature macro: SHIFT_BARRELPIPE_STICKY_EN (adds out_sticky).
module shift_barrelpipe
  import shift_pkg::*;
#(
  parameter int unsigned Bits   = 64,
  parameter int unsigned Stages = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   inp_valid,
  output logic                   inp_retry,
  input  logic [Bits-1:0]        inp_a,
  input  logic [log2w(Bits)-1:0] inp_sh,
  input  logic [1:0]             inp_mode,
  output logic                   out_valid,
  input  logic                   out_retry,
`ifdef SHIFT_BARRELPIPE_STICKY_EN
  output logic                   out_sticky,
`endif
  output logic [Bits-1:0]        out_b
);

  localparam int unsigned ShW    = log2w(Bits);
  localparam int unsigned Levels = ShW;
  localparam int unsigned Per    = (Levels + Stages - 1) / Stages;

  logic            w_valid [Stages+1];
  logic            w_retry [Stages+1];
  logic [Bits-1:0] w_data  [Stages+1];
  logic [ShW-1:0]  w_sh    [Stages+1];
  logic [1:0]      w_mode  [Stages+1];
  logic            w_unused_tail;
`ifdef SHIFT_BARRELPIPE_STICKY_EN
  logic            w_sticky [Stages+1];
  assign w_sticky[0] = 1'b0;
`endif

  assign w_valid[0]      = inp_valid;
  assign w_data[0]       = inp_a;
  assign w_sh[0]         = inp_sh;
  assign w_mode[0]       = inp_mode;
  assign w_retry[Stages] = out_retry;
  assign inp_retry       = w_retry[0];

  // Chain of stages; each takes ceil(Levels/Stages) levels, last gets the rest
  for (genvar s = 0; s < Stages; s++) begin : g_stage
    localparam int unsigned LoRaw = s * Per;
    localparam int unsigned HiRaw = (s + 1) * Per;
    localparam int unsigned Lo    = (LoRaw > Levels) ? Levels : LoRaw;
    localparam int unsigned Hi    = (HiRaw > Levels) ? Levels : HiRaw;

    shift_barrelpipe_stage #(
      .Bits (Bits),
      .ShW  (ShW),
      .Lo   (Lo),
      .Num  (Hi - Lo)
    ) u_stage (
      .clk      (clk),
      .reset_n  (reset_n),
      .i_valid  (w_valid[s]),
      .o_retry  (w_retry[s]),
      .i_data   (w_data[s]),
      .i_sh     (w_sh[s]),
      .i_mode   (w_mode[s]),
`ifdef SHIFT_BARRELPIPE_STICKY_EN
      .i_sticky (w_sticky[s]),
      .o_sticky (w_sticky[s+1]),
`endif
      .o_valid  (w_valid[s+1]),
      .i_retry  (w_retry[s+1]),
      .o_data   (w_data[s+1]),
      .o_sh     (w_sh[s+1]),
      .o_mode   (w_mode[s+1])
    );
  end

  // Amount and mode are not needed once the last level has been applied
  assign w_unused_tail = ^{w_sh[Stages], w_mode[Stages]};

  assign out_valid = w_valid[Stages];
  assign out_b     = w_data[Stages];
`ifdef SHIFT_BARRELPIPE_STICKY_EN
  assign out_sticky = w_sticky[Stages];
`endif

endmodule

// File: tb/tb_shift_barrelpipe.sv
// Self-checking bench for shift_barrelpipe: directed vectors, reset, backpressure,
// back-to-back streaming and randomized traffic on three Bits/Stages configurations.
module tb_shift_barrelpipe;

  logic clk;
  logic rst_n;

  // DUT 0: Bits=64, Stages=2
  logic        v0, or0, ir0, ov0;
  logic [63:0] a0, ob0;
  logic [5:0]  sh0;
  logic [1:0]  m0;
  // DUT 1: Bits=8, Stages=3
  logic        v1, or1, ir1, ov1;
  logic [7:0]  a1, ob1;
  logic [2:0]  sh1;
  logic [1:0]  m1;
  // DUT 2: Bits=32, Stages=5
  logic        v2, or2, ir2, ov2;
  logic [31:0] a2, ob2;
  logic [4:0]  sh2;
  logic [1:0]  m2;
`ifdef SHIFT_BARRELPIPE_STICKY_EN
  logic        os0, os1, os2;
`endif

  int n_checks;
  int n_fail;
  logic [64:0] exp_q[$];

  shift_barrelpipe #(.Bits(64), .Stages(2)) u_dut (
    .clk(clk), .reset_n(rst_n), .inp_valid(v0), .inp_retry(ir0), .inp_a(a0),
    .inp_sh(sh0), .inp_mode(m0), .out_valid(ov0), .out_retry(or0),
`ifdef SHIFT_BARRELPIPE_STICKY_EN
    .out_sticky(os0),
`endif
    .out_b(ob0));

  shift_barrelpipe #(.Bits(8), .Stages(3)) u_dut8 (
    .clk(clk), .reset_n(rst_n), .inp_valid(v1), .inp_retry(ir1), .inp_a(a1),
    .inp_sh(sh1), .inp_mode(m1), .out_valid(ov1), .out_retry(or1),
`ifdef SHIFT_BARRELPIPE_STICKY_EN
    .out_sticky(os1),
`endif
    .out_b(ob1));

  shift_barrelpipe #(.Bits(32), .Stages(5)) u_dut32 (
    .clk(clk), .reset_n(rst_n), .inp_valid(v2), .inp_retry(ir2), .inp_a(a2),
    .inp_sh(sh2), .inp_mode(m2), .out_valid(ov2), .out_retry(or2),
`ifdef SHIFT_BARRELPIPE_STICKY_EN
    .out_sticky(os2),
`endif
    .out_b(ob2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int bits_of(input int n);
    return (n == 0) ? 64 : (n == 1) ? 8 : 32;
  endfunction

  function automatic int stages_of(input int n);
    return (n == 0) ? 2 : (n == 1) ? 3 : 5;
  endfunction

  // Reference: each result bit taken straight from its source position in a
  function automatic logic [63:0] ref_shift(input int bits, input logic [63:0] a,
                                            input int sh, input int mode, output logic st);
    logic [63:0] b;
    int idx;
    b  = '0;
    st = 1'b0;
    for (int i = 0; i < bits; i++) begin
      case (mode)
        0: begin idx = (i + sh) % bits;        b[i] = a[idx[5:0]]; end
        1: begin idx = (i + bits - sh) % bits; b[i] = a[idx[5:0]]; end
        default: begin
          idx = i + sh;
          if (idx < bits) b[i] = a[idx[5:0]];
          else            b[i] = (mode == 3) ? a[bits-1] : 1'b0;
        end
      endcase
    end
    if (mode >= 2) for (int j = 0; j < sh; j++) st = st | a[j];
    return b;
  endfunction

  function automatic int pick_sh(input int bits);
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return 0;
    if (r == 1) return bits - 1;
    return $urandom_range(0, bits - 1);
  endfunction

  task automatic drive(input int n, input logic v, input logic [63:0] a, input int sh,
                       input logic [1:0] m, input logic r);
    case (n)
      0: begin v0 = v; a0 = a;       sh0 = 6'(sh); m0 = m; or0 = r; end
      1: begin v1 = v; a1 = a[7:0];  sh1 = 3'(sh); m1 = m; or1 = r; end
      default: begin v2 = v; a2 = a[31:0]; sh2 = 5'(sh); m2 = m; or2 = r; end
    endcase
  endtask

  task automatic sample(input int n, output logic ir, output logic ov,
                        output logic [63:0] ob, output logic os);
    os = 1'b0;
    case (n)
      0: begin
        ir = ir0; ov = ov0; ob = ob0;
`ifdef SHIFT_BARRELPIPE_STICKY_EN
        os = os0;
`endif
      end
      1: begin
        ir = ir1; ov = ov1; ob = {56'b0, ob1};
`ifdef SHIFT_BARRELPIPE_STICKY_EN
        os = os1;
`endif
      end
      default: begin
        ir = ir2; ov = ov2; ob = {32'b0, ob2};
`ifdef SHIFT_BARRELPIPE_STICKY_EN
        os = os2;
`endif
      end
    endcase
  endtask

  task automatic test_reset();
    logic ir, ov, os;
    logic [63:0] ob;
    rst_n = 1'b0;
    for (int n = 0; n < 3; n++) drive(n, 1'b0, 64'h0, 0, 2'b00, 1'b0);
    #12;
    sample(0, ir, ov, ob, os);
    n_checks++; if (ov !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", ov); end
    n_checks++; if (ob !== 64'h0) begin n_fail++; $display("FAIL reset_out_b: got %h expected 0", ob); end
    n_checks++; if (ir !== 1'b0) begin n_fail++; $display("FAIL reset_inp_retry: got %b expected 0", ir); end
    n_checks++; if (os !== 1'b0) begin n_fail++; $display("FAIL reset_out_sticky: got %b expected 0", os); end
    n_checks++; if (ov1 !== 1'b0 || ov2 !== 1'b0) begin n_fail++; $display("FAIL reset_other_valid: got %b%b expected 00", ov1, ov2); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_vectors();
    logic [63:0] ta [10];
    int          ts [10];
    int          tm [10];
    logic [63:0] te [10];
    logic        tst[10];
    logic        ir, ov, os;
    logic [63:0] ob, rnd;
    ta[0] = 64'h0123_4567_89AB_CDEF; ts[0] = 4;  tm[0] = 0; te[0] = 64'hF012_3456_789A_BCDE; tst[0] = 1'b0;
    ta[1] = 64'h0123_4567_89AB_CDEF; ts[1] = 8;  tm[1] = 1; te[1] = 64'h2345_6789_ABCD_EF01; tst[1] = 1'b0;
    ta[2] = 64'h0123_4567_89AB_CDEF; ts[2] = 60; tm[2] = 2; te[2] = 64'h0;                   tst[2] = 1'b1;
    ta[3] = 64'h8000_0000_0000_0000; ts[3] = 63; tm[3] = 3; te[3] = 64'hFFFF_FFFF_FFFF_FFFF; tst[3] = 1'b0;
    ta[4] = 64'h1;                   ts[4] = 1;  tm[4] = 2; te[4] = 64'h0;                   tst[4] = 1'b1;
    ta[5] = 64'h1;                   ts[5] = 1;  tm[5] = 0; te[5] = 64'h8000_0000_0000_0000; tst[5] = 1'b0;
    for (int i = 6; i < 10; i++) begin
      rnd = {$urandom(), $urandom()} | 64'h8000_0000_0000_0001;
      ta[i] = rnd; ts[i] = 0; tm[i] = i - 6; te[i] = rnd; tst[i] = 1'b0;
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      drive(0, 1'b1, ta[i], ts[i], 2'(tm[i]), 1'b0);
      #1; sample(0, ir, ov, ob, os);
      n_checks++; if (ir !== 1'b0) begin n_fail++; $display("FAIL vec%0d_inp_retry: got %b expected 0", i, ir); end
      @(negedge clk);
      drive(0, 1'b0, 64'h0, 0, 2'b00, 1'b0);
      #1; sample(0, ir, ov, ob, os);
      n_checks++; if (ov !== 1'b0) begin n_fail++; $display("FAIL vec%0d_early_valid: got %b expected 0", i, ov); end
      @(negedge clk);
      #1; sample(0, ir, ov, ob, os);
      n_checks++; if (ov !== 1'b1) begin n_fail++; $display("FAIL vec%0d_latency_valid: got %b expected 1", i, ov); end
      n_checks++; if (ob !== te[i]) begin n_fail++; $display("FAIL vec%0d_out_b: got %h expected %h", i, ob, te[i]); end
`ifdef SHIFT_BARRELPIPE_STICKY_EN
      n_checks++; if (os !== tst[i]) begin n_fail++; $display("FAIL vec%0d_sticky: got %b expected %b", i, os, tst[i]); end
`endif
    end
  endtask

  // Generic stream engine; pattern 0 random, 1 burst with retry window, 2 no backpressure
  task automatic run_stream(input string name, input int n, input int nreq,
                            input int pattern, input int max_cycles);
    int bits, stg, sent, cyc, sh, mode;
    logic v, r, ir, ov, os, irx, ovx, osx, hold, hs, st, saw_ir;
    logic [63:0] a, ob, obx, hb, eb;
    logic [64:0] ent;
    bits = bits_of(n); stg = stages_of(n);
    sent = 0; cyc = 0; hold = 1'b0; hb = '0; hs = 1'b0; saw_ir = 1'b0;
    exp_q.delete();
    while ((sent < nreq || exp_q.size() != 0) && cyc < max_cycles) begin
      @(negedge clk);
      v = (sent < nreq) && (pattern != 0 || $urandom_range(0, 3) != 0);
      case (pattern)
        0:       r = ($urandom_range(0, 2) == 0);
        1:       r = (cyc >= 3 && cyc <= 7);
        default: r = 1'b0;
      endcase
      a = {$urandom(), $urandom()}; sh = pick_sh(bits); mode = $urandom_range(0, 3);
      drive(n, v, a, sh, 2'(mode), r);
      #1; sample(n, ir, ov, ob, os);
      if (hold) begin
        n_checks++;
        if (ov !== 1'b1 || ob !== hb || os !== hs) begin
          n_fail++; $display("FAIL %s_hold_stable: got v=%b b=%h s=%b expected v=1 b=%h s=%b", name, ov, ob, os, hb, hs);
        end
      end
      if (pattern == 1 && ir === 1'b1 && !saw_ir) begin
        drive(n, 1'b0, a, sh, 2'(mode), r);
        #1; sample(n, irx, ovx, obx, osx);
        n_checks++; if (irx !== 1'b1) begin n_fail++; $display("FAIL %s_retry_indep_valid: got %b expected 1", name, irx); end
        drive(n, v, a, sh, 2'(mode), r);
        #1;
      end
      if (ir === 1'b1) saw_ir = 1'b1;
      if (v && ir === 1'b0) begin
        eb = ref_shift(bits, a, sh, mode, st);
        exp_q.push_back({st, eb});
        sent++;
      end
      if (ov === 1'b1 && !r) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL %s_spurious_out: got %h expected none", name, ob);
        end else begin
          ent = exp_q.pop_front();
          if (ob !== ent[63:0]) begin n_fail++; $display("FAIL %s_out_b: got %h expected %h", name, ob, ent[63:0]); end
`ifdef SHIFT_BARRELPIPE_STICKY_EN
          n_checks++;
          if (os !== ent[64]) begin n_fail++; $display("FAIL %s_sticky: got %b expected %b", name, os, ent[64]); end
`endif
        end
      end
      hold = (ov === 1'b1) && r; hb = ob; hs = os;
      cyc++;
    end
    @(negedge clk);
    drive(n, 1'b0, 64'h0, 0, 2'b00, 1'b0);
    n_checks++;
    if (sent != nreq || exp_q.size() != 0) begin
      n_fail++; $display("FAIL %s_drain: got sent=%0d pending=%0d expected sent=%0d pending=0", name, sent, exp_q.size(), nreq);
    end
    if (pattern == 1) begin
      n_checks++; if (saw_ir !== 1'b1) begin n_fail++; $display("FAIL %s_retry_seen: got %b expected 1", name, saw_ir); end
    end
    if (pattern == 2) begin
      n_checks++; if (saw_ir !== 1'b0) begin n_fail++; $display("FAIL %s_no_retry: got %b expected 0", name, saw_ir); end
      n_checks++; if (cyc != nreq + stg) begin n_fail++; $display("FAIL %s_throughput: got %0d cycles expected %0d", name, cyc, nreq + stg); end
    end
  endtask

  task automatic test_backpressure();
    run_stream("backpressure", 0, 10, 1, 100);
  endtask

  task automatic test_back_to_back();
    run_stream("b2b64", 0, 40, 2, 200);
    run_stream("b2b8", 1, 40, 2, 200);
    run_stream("b2b32", 2, 40, 2, 200);
  endtask

  task automatic test_random();
    run_stream("rand64", 0, 300, 0, 3000);
    run_stream("rand8", 1, 300, 0, 3000);
    run_stream("rand32", 2, 300, 0, 3000);
  endtask

  task automatic test_reset_midflight();
    logic ir, ov, os, st;
    logic [63:0] ob, a, eb;
    @(negedge clk); drive(0, 1'b1, 64'hDEAD_BEEF_0000_1111, 3, 2'b00, 1'b0);
    @(negedge clk); drive(0, 1'b1, 64'h1234_5678_9ABC_DEF0, 5, 2'b10, 1'b0);
    @(negedge clk); drive(0, 1'b0, 64'h0, 0, 2'b00, 1'b0);
    #1; sample(0, ir, ov, ob, os);
    n_checks++; if (ov !== 1'b1) begin n_fail++; $display("FAIL midrst_inflight: got %b expected 1", ov); end
    rst_n = 1'b0;
    #1; sample(0, ir, ov, ob, os);
    n_checks++; if (ov !== 1'b0) begin n_fail++; $display("FAIL midrst_out_valid: got %b expected 0", ov); end
    n_checks++; if (ob !== 64'h0) begin n_fail++; $display("FAIL midrst_out_b: got %h expected 0", ob); end
    n_checks++; if (ir !== 1'b0) begin n_fail++; $display("FAIL midrst_inp_retry: got %b expected 0", ir); end
    @(negedge clk);
    rst_n = 1'b1;
    a = {$urandom(), $urandom()};
    eb = ref_shift(64, a, 17, 3, st);
    drive(0, 1'b1, a, 17, 2'b11, 1'b0);
    @(negedge clk); drive(0, 1'b0, 64'h0, 0, 2'b00, 1'b0);
    #1; sample(0, ir, ov, ob, os);
    n_checks++; if (ov !== 1'b0) begin n_fail++; $display("FAIL midrst_stale_out: got %b expected 0", ov); end
    @(negedge clk); #1; sample(0, ir, ov, ob, os);
    n_checks++; if (ov !== 1'b1 || ob !== eb) begin n_fail++; $display("FAIL midrst_first_result: got v=%b b=%h expected v=1 b=%h", ov, ob, eb); end
    @(negedge clk); #1; sample(0, ir, ov, ob, os);
    n_checks++; if (ov !== 1'b0) begin n_fail++; $display("FAIL midrst_ghost: got %b expected 0", ov); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_vectors();
    test_backpressure();
    test_back_to_back();
    test_reset_midflight();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
